// File: rtl/array_controller.sv
// Sequences multi-tile jobs across input/weight/output routers: load, drain, output, next tile.
// Latency: psum release ROUTER_COUNT cycles after drain entry; pops follow ready by one cycle.
// Backpressure: i_stall suppresses pops; OUT holds until the output router reports done.
module array_controller #(
    parameter int IR_COUNT     = 2,
    parameter int WR_COUNT     = 2,
    parameter int ROUTER_COUNT = 4,
    parameter int TILE_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [TILE_WIDTH-1:0] i_tile_count,
    input  logic                  i_stall,
    input  logic [IR_COUNT-1:0]   i_ir_ready,
    input  logic [WR_COUNT-1:0]   i_wr_ready,
    input  logic [IR_COUNT-1:0]   i_ir_done,
    input  logic [WR_COUNT-1:0]   i_wr_done,
    input  logic                  i_or_done,
    output logic                  o_ir_en,
    output logic                  o_wr_en,
    output logic [IR_COUNT-1:0]   o_ir_pop_en,
    output logic [WR_COUNT-1:0]   o_wr_pop_en,
    output logic                  o_psum_out_en,
    output logic                  o_or_en,
    output logic                  o_tile_next,
    output logic [TILE_WIDTH-1:0] o_tile_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int DW = (ROUTER_COUNT > 1) ? $clog2(ROUTER_COUNT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ROUTER_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state, state_n;
    logic [TILE_WIDTH-1:0] tile_cnt, tile_cnt_n;
    logic [TILE_WIDTH-1:0] tile_idx, tile_idx_n;
    logic [DW-1:0]         drain_cnt, drain_cnt_n;
    logic                  en, en_n;
    logic                  pop, pop_n;
    logic                  psum, psum_n;
    logic                  or_en, or_en_n;
    logic                  tile_next, tile_next_n;
    logic                  busy, busy_n;
    logic                  done, done_n;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= S_IDLE;
            tile_cnt  <= '0;
            tile_idx  <= '0;
            drain_cnt <= '0;
            en        <= 1'b0;
            pop       <= 1'b0;
            psum      <= 1'b0;
            or_en     <= 1'b0;
            tile_next <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            tile_cnt  <= tile_cnt_n;
            tile_idx  <= tile_idx_n;
            drain_cnt <= drain_cnt_n;
            en        <= en_n;
            pop       <= pop_n;
            psum      <= psum_n;
            or_en     <= or_en_n;
            tile_next <= tile_next_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        tile_cnt_n  = tile_cnt;
        tile_idx_n  = tile_idx;
        drain_cnt_n = drain_cnt;
        en_n        = en;
        or_en_n     = or_en;
        pop_n       = 1'b0;
        psum_n      = 1'b0;
        tile_next_n = 1'b0;
        done_n      = 1'b0;
        if (i_reg_clear) begin
            state_n     = S_IDLE;
            tile_cnt_n  = '0;
            tile_idx_n  = '0;
            drain_cnt_n = '0;
            en_n        = 1'b0;
            or_en_n     = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_tile_count != '0) begin
                            tile_cnt_n = i_tile_count;
                            tile_idx_n = '0;
                            en_n       = 1'b1;
                            state_n    = S_LOAD;
                        end else begin
                            state_n = S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    // Tile completion wins over a coincident ready, so no pop leaks into DRAIN.
                    if ((&i_ir_done) && (&i_wr_done)) begin
                        drain_cnt_n = '0;
                        state_n     = S_DRAIN;
                    end else begin
                        pop_n = (&i_ir_ready) & (&i_wr_ready) & ~i_stall;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt < DRAIN_LAST) begin
                        drain_cnt_n = drain_cnt + 1'b1;
                    end else begin
                        psum_n  = 1'b1;
                        or_en_n = 1'b1;
                        state_n = S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_or_done) begin
                        or_en_n = 1'b0;
                        state_n = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (tile_idx == tile_cnt - 1'b1) begin
                        state_n = S_DONE;
                    end else begin
                        tile_idx_n  = tile_idx + 1'b1;
                        tile_next_n = 1'b1;
                        state_n     = S_LOAD;
                    end
                end
                S_DONE: begin
                    done_n  = 1'b1;
                    en_n    = 1'b0;
                    state_n = S_IDLE;
                end
                default: begin
                    en_n    = 1'b0;
                    or_en_n = 1'b0;
                    state_n = S_IDLE;
                end
            endcase
        end
        busy_n = (state_n != S_IDLE);
    end

    assign o_ir_en       = en;
    assign o_wr_en       = en;
    assign o_ir_pop_en   = {IR_COUNT{pop}};
    assign o_wr_pop_en   = {WR_COUNT{pop}};
    assign o_psum_out_en = psum;
    assign o_or_en       = or_en;
    assign o_tile_next   = tile_next;
    assign o_tile_idx    = tile_idx;
    assign o_busy        = busy;
    assign o_done        = done;

endmodule

// File: doc/array_controller.md
ARRAY_CONTROLLER -- requirements
Module: array_controller

Interface
REQ-001 Parameter IR_COUNT, default 2: number of input routers controlled.
REQ-002 Parameter WR_COUNT, default 2: number of weight routers controlled.
REQ-003 Parameter ROUTER_COUNT, default 4: array depth; sets drain latency.
REQ-004 Parameter TILE_WIDTH, default 8: width of tile count and tile index.
REQ-005 i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 i_nrst  in  1  asynchronous, active-low reset.
REQ-007 i_reg_clear  in  1  synchronous clear.
REQ-008 i_start  in  1  start pulse for a multi-tile job.
REQ-009 i_tile_count  in  TILE_WIDTH  number of tiles in the job; latched on accepted i_start.
REQ-010 i_stall  in  1  downstream backpressure; blocks pops while high.
REQ-011 i_ir_ready / i_wr_ready  in  IR_COUNT / WR_COUNT  per-router data-ready flags.
REQ-012 i_ir_done / i_wr_done  in  IR_COUNT / WR_COUNT  per-router tile-complete flags.
REQ-013 i_or_done  in  1  output router finished draining the current tile.
REQ-014 o_ir_en / o_wr_en  out  1  router enables.
REQ-015 o_ir_pop_en / o_wr_pop_en  out  IR_COUNT / WR_COUNT  per-router pop strobes.
REQ-016 o_psum_out_en  out  1  one-cycle partial-sum release pulse.
REQ-017 o_or_en  out  1  output router enable.
REQ-018 o_tile_next  out  1  one-cycle pulse that restarts the routers for the next tile.
REQ-019 o_tile_idx  out  TILE_WIDTH  index of the current tile.
REQ-020 o_busy  out  1  high in every state except IDLE.
REQ-021 o_done  out  1  one-cycle job-complete pulse.

Function
REQ-022 All outputs SHALL be registered; FSM states are IDLE, LOAD, DRAIN, OUT, NEXT, DONE.
REQ-023 IDLE: on i_start with i_tile_count!=0, SHALL latch the count, clear o_tile_idx, set o_ir_en/o_wr_en=1, and go to LOAD.
REQ-024 IDLE: on i_start with i_tile_count==0, SHALL go directly to DONE.
REQ-025 i_start SHALL be ignored in every state other than IDLE.
REQ-026 LOAD: all pop bits SHALL be 1 in the cycle after any cycle in which &i_ir_ready, &i_wr_ready and ~i_stall are all true; otherwise all pop bits SHALL be 0.
REQ-027 LOAD: when &i_ir_done and &i_wr_done are both true, SHALL go to DRAIN, clear the drain counter, and force the pops to 0; this takes priority over a simultaneous ready.
REQ-028 DRAIN: the counter SHALL increment while it is below ROUTER_COUNT-1; at ROUTER_COUNT-1, o_psum_out_en and o_or_en SHALL be set to 1 and the FSM SHALL go to OUT.
REQ-029 Resulting latency: o_psum_out_en SHALL be high exactly ROUTER_COUNT cycles after the first DRAIN cycle, for one cycle.
REQ-030 OUT: o_psum_out_en SHALL clear; o_or_en SHALL hold at 1 until i_or_done, then clear while the FSM goes to NEXT.
REQ-031 NEXT: if o_tile_idx==latched count-1, SHALL go to DONE.
REQ-032 NEXT: otherwise SHALL increment o_tile_idx, pulse o_tile_next, and return to LOAD.
REQ-033 DONE: SHALL pulse o_done for one cycle, clear o_ir_en/o_wr_en, and go to IDLE.
REQ-034 i_reg_clear SHALL have priority over all other inputs and return every register to its reset value, mid-job included.
REQ-035 Unreachable state encodings SHALL recover to IDLE.

Reset
REQ-036 While i_nrst=0, all outputs, counters and the latched count SHALL be 0 and the FSM SHALL be in IDLE, independent of i_clk.
REQ-037 Deassertion of reset SHALL NOT by itself produce any pulse.

Verification
REQ-038 Parameters IR_COUNT=2, WR_COUNT=2, ROUTER_COUNT=4; i_start with i_tile_count=1; full handshake -> o_psum_out_en high in the 4th cycle after DRAIN entry; o_done one cycle; o_busy then low.
REQ-039 i_ir_ready=2'b11, i_wr_ready=2'b01 -> pops stay 0; i_wr_ready->2'b11 -> pops 4'b1111 next cycle; i_stall=1 -> pops 0 the next cycle.
REQ-040 i_tile_count=3 -> o_tile_next pulses twice; o_tile_idx steps 0,1,2; one o_done after the third i_or_done.
REQ-041 i_start with i_tile_count=0 -> o_done two cycles later; o_ir_en never asserts.
REQ-042 i_reg_clear asserted in OUT with o_tile_idx=1 -> next cycle all outputs 0, FSM IDLE; a new i_start is accepted.
REQ-043 i_nrst pulsed low mid-DRAIN -> outputs 0 immediately; after release, i_start runs a clean job.
